// File: rtl/rgb_ordered_dither.sv
// rgb_ordered_dither: 2-stage Bayer/temporal ditherer; define RGB_DITHER_LFSR_EN for per-channel LFSR dither in mode 11
module rgb_ordered_dither #(
  parameter int CHANNELS    = 3,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 1,
  parameter int MATRIX_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10:0]               hc,
  input  logic [10:0]               vc,
  input  logic [CHANNELS*IN_W-1:0]  pixel,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  output logic [CHANNELS*OUT_W-1:0] out_pixel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                active_mode
);
  localparam int L = MATRIX_LOG2;
  localparam int K = 2 * L;
  localparam int S = IN_W - OUT_W;
  function automatic logic [K-1:0] bayer(input logic [L-1:0] x, input logic [L-1:0] y);
    logic [K-1:0] b;
    b = '0;
    for (int i = 0; i < L; i++) b[2*(L-1-i) +: 2] = {x[i] ^ y[i], y[i]};
    return b;
  endfunction
  logic                      en, xfer, fs;
  logic [1:0]                mode_eff, active_mode_q;
  logic [7:0]                fc_q, fc_d;
  logic [L-1:0]              bx, by;
  logic [S-1:0]              bt;
  logic [CHANNELS*IN_W-1:0]  pix1_q;
  logic [CHANNELS*S-1:0]     thr1_q, thr_d;
  logic                      trunc1_q, v1_q, out_valid_q;
  logic [CHANNELS*OUT_W-1:0] q_d, out_pixel_q;
  assign en          = !out_valid_q || out_ready;
  assign in_ready    = en;
  assign xfer        = in_valid && en;
  assign fs          = xfer && hc == 11'd0 && vc == 11'd0;
  assign mode_eff    = fs ? mode : active_mode_q;
  assign fc_d        = fs ? fc_q + 8'd1 : fc_q;
  assign bx          = hc[L-1:0] + (mode_eff == 2'b10 ? fc_d[L-1:0] : '0);
  assign by          = vc[L-1:0] + (mode_eff == 2'b10 ? fc_d[L-1:0] : '0);
  // (B << S) >> K covers both the left-shift and right-shift threshold scalings
  assign bt          = S'({bayer(bx, by), {S{1'b0}}} >> K);
  assign out_pixel   = out_pixel_q;
  assign out_valid   = out_valid_q;
  assign active_mode = active_mode_q;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [IN_W-1:0] px;
    logic [OUT_W:0]  sum;
    assign px  = pix1_q[c*IN_W +: IN_W];
    assign sum = {1'b0, px[IN_W-1:S]} + (OUT_W+1)'(!trunc1_q && px[S-1:0] > thr1_q[c*S +: S]);
    assign q_d[c*OUT_W +: OUT_W] = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
`ifdef RGB_DITHER_LFSR_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk)
      if (!reset) lfsr_q <= 16'hACE1 ^ 16'(c);
      else if (xfer) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign thr_d[c*S +: S] = mode_eff == 2'b11 ? lfsr_q[S-1:0] : bt;
`else
    assign thr_d[c*S +: S] = bt;
`endif
  end
  always_ff @(posedge clk)
    if (!reset) begin
      v1_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      out_pixel_q   <= '0;
      fc_q          <= '0;
      active_mode_q <= 2'b01;
    end else begin
      fc_q          <= fc_d;
      active_mode_q <= mode_eff;
      if (en) begin
        v1_q        <= in_valid;
        pix1_q      <= pixel;
        thr1_q      <= thr_d;
        trunc1_q    <= mode_eff == 2'b00;
        out_valid_q <= v1_q;
        out_pixel_q <= q_d;
      end
    end
endmodule

// File: tb/tb_rgb_ordered_dither.sv
// tb_rgb_ordered_dither: directed checks of the default 3x8->1 ditherer plus a 1x8->4, 8x8-matrix instance
module tb_rgb_ordered_dither;
  logic        clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [10:0] hc, vc;
  logic [23:0] pixel;
  logic [1:0]  mode, active_mode;
  logic [2:0]  out_pixel;
  logic [10:0] hc2, vc2;
  logic [7:0]  px2;
  logic        iv2, ir2, ov2;
  logic        or2 = 1'b1;
  logic [1:0]  mode2 = 2'b01;
  logic [1:0]  am2;
  logic [3:0]  op2;
  rgb_ordered_dither u_dut (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pixel(pixel), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .active_mode(active_mode)
  );
  rgb_ordered_dither #(.CHANNELS(1), .IN_W(8), .OUT_W(4), .MATRIX_LOG2(3)) u_wide (
    .clk(clk), .reset(reset), .hc(hc2), .vc(vc2), .pixel(px2), .in_valid(iv2),
    .in_ready(ir2), .mode(mode2), .out_pixel(op2), .out_valid(ov2),
    .out_ready(or2), .active_mode(am2)
  );
  int         n_err = 0, n_chk = 0, stall_cnt = 0, ones = 0, zeros = 0, cnt08;
  logic [2:0] expq[$];
  logic [2:0] cur_exp, held;
  logic       prev_stall = 1'b0, last_xfer = 1'b0;
  int         bay4[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] e40(input int h, input int v, input int f);
    return bay4[((v + f) % 4) * 4 + (h + f) % 4] < 8 ? 3'd7 : 3'd0;
  endfunction
  function automatic logic [23:0] pk(input logic [2:0] k);
    return {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction
  task automatic tick();
    logic acc;
    out_ready = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    #1;
    last_xfer = in_valid && in_ready && reset;
    acc = out_valid && out_ready;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) chk("spurious", {31'd0, out_valid}, 0);
      else chk("pix", {29'd0, out_pixel}, {29'd0, expq[0]});
      if (prev_stall) chk("hold", {29'd0, out_pixel}, {29'd0, held});
      if (!out_ready) chk("in_ready_stall", {31'd0, in_ready}, 0);
    end
    prev_stall = (out_valid === 1'b1) && !out_ready;
    held = out_pixel;
    if (acc === 1'b1) begin
      ones  += (out_pixel == 3'd7);
      zeros += (out_pixel == 3'd0);
    end
    @(posedge clk);
    if (!reset) expq.delete();
    else begin
      if (acc === 1'b1 && expq.size() > 0) void'(expq.pop_front());
      if (last_xfer === 1'b1) expq.push_back(cur_exp);
    end
    @(negedge clk);
  endtask
  task automatic send(input int h, input int v, input logic [23:0] p, input logic [1:0] m, input logic [2:0] e);
    int n = 0;
    hc = 11'(h); vc = 11'(v); pixel = p; mode = m; cur_exp = e; in_valid = 1'b1;
    do begin tick(); n++; end while (last_xfer !== 1'b1 && n < 20);
    if (last_xfer !== 1'b1) chk("send_timeout", {31'd0, last_xfer}, 1);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (expq.size() > 0 && n < 10) begin tick(); n++; end
    chk("drain", expq.size(), 0);
    tick(); tick();
  endtask
  task automatic run2(input logic [7:0] val, input logic [3:0] e, input bit count_only, output int cnt);
    cnt = 0;
    for (int i = 0; i < 66; i++) begin
      if (i >= 2) begin
        if (count_only) begin
          chk("w_valid", {31'd0, ov2}, 1);
          cnt += (op2 == 4'd1);
        end else chk("w_sat", {27'd0, ov2, op2}, {27'd0, 1'b1, e});
      end
      iv2 = i < 64; hc2 = 11'(i % 8); vc2 = 11'(i / 8); px2 = val;
      @(posedge clk); @(negedge clk);
    end
    iv2 = 1'b0;
  endtask
  initial begin
    reset = 1'b0; in_valid = 1'b0; mode = 2'b01; out_ready = 1'b1; hc = '0; vc = '0; pixel = '0;
    cur_exp = '0; held = '0; iv2 = 1'b0; hc2 = '0; vc2 = '0; px2 = '0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_pix", {29'd0, out_pixel}, 0);
    chk("rst_mode", {30'd0, active_mode}, 1);
    chk("rst_ready", {31'd0, in_ready}, 1);
    ones = 0; zeros = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) chk("lat1", {31'd0, out_valid}, 0);
      if (i == 2) chk("lat2", {31'd0, out_valid}, 1);
      send(i % 4, i / 4, {3{8'h40}}, 2'b01, e40(i % 4, i / 4, 0));
    end
    drain();
    chk("ord_ones", ones, 8);
    chk("ord_zeros", zeros, 8);
    send(0, 0, 24'h7F80FF, 2'b00, 3'b011);
    send(1, 0, 24'h7F80FF, 2'b01, 3'b011);
    send(2, 1, 24'h7F80FF, 2'b01, 3'b011);
    send(3, 3, 24'h7F80FF, 2'b00, 3'b011);
    send(6, 9, 24'h7F80FF, 2'b00, 3'b011);
    drain();
    chk("am_trunc", {30'd0, active_mode}, 0);
    send(0, 0, 24'h7F00FF, 2'b01, 3'b101);
    send(1, 2, 24'h7F00FF, 2'b01, 3'b101);
    send(0, 3, 24'h7F00FF, 2'b01, 3'b101);
    send(3, 3, 24'h7F00FF, 2'b01, 3'b101);
    send(2, 2, 24'h000000, 2'b01, 3'b000);
    send(3, 2, 24'hFFFFFF, 2'b01, 3'b111);
    send(0, 0, {3{8'h40}}, 2'b11, 3'd7);
    send(1, 1, {3{8'h40}}, 2'b11, 3'd7);
    send(2, 1, {3{8'h40}}, 2'b11, 3'd0);
    drain();
    chk("am_lfsr_off", {30'd0, active_mode}, 3);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) stall_cnt = 5;
      send(k, 0, pk(3'(k)), 2'b01, 3'(k));
    end
    drain();
    send(0, 0, {3{8'h40}}, 2'b01, 3'd7);
    chk("am_set", {30'd0, active_mode}, 1);
    send(1, 0, {3{8'h40}}, 2'b01, 3'd0);
    send(5, 3, {3{8'h40}}, 2'b00, 3'd7);
    chk("am_hold1", {30'd0, active_mode}, 1);
    send(6, 3, {3{8'h40}}, 2'b00, 3'd0);
    chk("am_hold2", {30'd0, active_mode}, 1);
    send(0, 0, {3{8'h40}}, 2'b00, 3'd0);
    chk("am_new", {30'd0, active_mode}, 0);
    send(1, 1, {3{8'h40}}, 2'b00, 3'd0);
    drain();
    send(2, 2, 24'hFFFFFF, 2'b00, 3'd7);
    send(3, 2, 24'h000000, 2'b00, 3'd0);
    reset = 1'b0; stall_cnt = 1;
    tick();
    reset = 1'b1;
    chk("rst2_valid", {31'd0, out_valid}, 0);
    chk("rst2_mode", {30'd0, active_mode}, 1);
    tick(); tick(); tick();
    chk("rst2_idle", {31'd0, out_valid}, 0);
    send(0, 0, {8'h21, 8'h20, 8'h21}, 2'b10, 3'b101);
    for (int i = 1; i < 16; i++) send(i % 4, i / 4, {3{8'h40}}, 2'b10, e40(i % 4, i / 4, 1));
    for (int i = 0; i < 16; i++) send(i % 4, i / 4, {3{8'h40}}, 2'b10, e40(i % 4, i / 4, 2));
    drain();
    chk("am_temporal", {30'd0, active_mode}, 2);
    run2(8'hFF, 4'hF, 1'b0, cnt08);
    run2(8'hF8, 4'hF, 1'b0, cnt08);
    run2(8'h08, 4'h0, 1'b1, cnt08);
    chk("w08_cnt", cnt08, 32);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rgb_ordered_dither.md
Name: rgb_ordered_dither

Overview:
Parametrised multi-channel ordered (Bayer) ditherer for the video output path. It sits between the pixel source and the low-bit-depth DAC/pin driver and reduces each IN_W-bit channel to OUT_W bits using a position-dependent threshold. It supports selectable truncate, ordered and temporally rotated modes. A 2-stage pipeline with valid/ready handshake carries the pixels through.

Parameters:
CHANNELS, 3, number of colour channels; channel CHANNELS-1 in the MSBs (R), channel 0 in the LSBs (B)
IN_W, 8, input bits per channel
OUT_W, 1, output bits per channel; IN_W-OUT_W >= 1 required
MATRIX_LOG2, 2, Bayer matrix is N x N with N = 2**MATRIX_LOG2; legal values 1..3

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
hc  input  11  horizontal pixel coordinate of input pixel
vc  input  11  vertical pixel coordinate of input pixel
pixel  input  CHANNELS*IN_W  packed input pixel
in_valid  input  1  input pixel/coordinates valid
in_ready  output  1  block can accept input this cycle
mode  input  2  00 truncate, 01 ordered, 10 ordered+temporal, 11 LFSR (see option)
out_pixel  output  CHANNELS*OUT_W  packed dithered pixel
out_valid  output  1  out_pixel valid
out_ready  input  1  downstream accepts out_pixel
active_mode  output  2  mode currently in effect

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_pixel=0, both pipeline valid bits=0, frame_cnt=0, active_mode=01, LFSRs to seed 16'hACE1 XOR channel index.
- Advance enable: en = !out_valid || out_ready. in_ready = en (combinational). Transfer occurs when in_valid && in_ready. Both stages shift together when en=1 and hold all contents when en=0.
- Latency: 2 cycles from accepted input to out_valid with out_ready held high. Full throughput is 1 pixel/clk.
- Stage 1 registers pixel, the per-channel threshold T and a valid bit. Stage 2 registers the quantised result and drives out_valid/out_pixel.
- Frame start: an accepted pixel with hc==0 and vc==0.
  - active_mode <= mode on that transfer. mode is ignored at every other time, so there is no mid-frame tearing.
  - The new mode applies to the frame-start pixel itself.
  - frame_cnt (8-bit) increments on the same transfer and wraps 255->0.
- Bayer matrix B(x,y), values 0..N*N-1:
  - B1 = [[0,2],[3,1]].
  - B_2n(x,y) = 4*B_n(x mod n, y mod n) + B1(x div n, y div n).
  - N=4 rows: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
- Coordinates:
  - Mode 01: x = hc mod N, y = vc mod N.
  - Mode 10: x = (hc + frame_cnt) mod N, y = (vc + frame_cnt) mod N. frame_cnt is the value after the frame-start increment.
- Threshold, with S = IN_W-OUT_W and K = 2*MATRIX_LOG2:
  - T = B << (S-K) if S >= K, else B >> (K-S).
  - T has width S.
- Per channel c:
  - base = in_c >> S; res = in_c[S-1:0].
  - q = base + (res > T ? 1 : 0).
  - Saturate q to 2**OUT_W - 1. There is no wrap.
  - Mode 00: q = base, with no rounding.
- Boundary rules:
  - Input all-zeros always outputs 0.
  - Input all-ones always outputs all-ones.
  - hc/vc wrap is handled purely by the mod arithmetic.
  - Synchronous reset mid-stream flushes both stages. Pixels in flight are dropped, not emitted.
  - If out_ready is low while out_valid is high, out_pixel stays stable until accepted.

Optional Feature:
- Macro: RGB_DITHER_LFSR_EN.
- Defined: each channel owns a 16-bit Fibonacci LFSR, taps 16,14,13,11. It steps once per accepted pixel in every mode.
- Defined, mode 11: T = LFSR[S-1:0], i.e. random dither.
- Undefined: no LFSR logic is built and mode 11 behaves exactly as mode 01.

Test Plan:
- Defaults, mode 01 at frame start, 16 pixels over a 4x4 window (hc,vc 0..3), R=G=B=8'h40, out_ready=1 -> exactly 8 of 16 outputs are 3'b111 (where B<8), the rest 3'b000; first out_valid 2 cycles after the first transfer.
- Mode 00, pixel 24'h7F80FF -> out_pixel 3'b011 for every hc/vc. Mode 01 with 24'h7F00FF -> 3'b101 everywhere (0x7F: res 127 > max T 120).
- Backpressure: stream 10 pixels, out_ready low for 5 cycles mid-stream -> no pixel lost or duplicated, out_pixel stable while stalled, in_ready low while stalled.
- Mode change: mode switched 01->00 at hc=5,vc=3 -> active_mode stays 01 until the next hc=0,vc=0 transfer, then 00. Mode 10 over frames 1 and 2 -> threshold pattern shifted diagonally by 1.
- Reset: assert reset=0 for 1 clk with both stages full -> out_valid=0 next cycle, frame_cnt=0, active_mode=01, no stale pixel ever emitted.
- IN_W=8, OUT_W=4, MATRIX_LOG2=3, CHANNELS=1, input 8'hFF and 8'hF8 in mode 01 -> output 4'hF at all 64 positions, with no saturation wrap to 0.
